shift_scheduler: RTL and testbench

SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

---
 rtl/shift_scheduler.sv | 75 +++++++
 tb/tb_shift_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_scheduler.sv
// shift_scheduler: round-robin arbiter feeding one requester's word at a time into an external shift register.
// Define SHIFT_BACK_TO_BACK_EN to grant the next word in the final-slice cycle instead of idling one cycle.
module shift_scheduler #(
  parameter int requesters = 4,
  parameter int depth = 4,
  parameter int width = 1
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [requesters-1:0]               request,
  input  logic [requesters*depth*width-1:0]   data,
  input  logic                                stall,
  output logic [requesters-1:0]               grant,
  output logic                                shift_enable,
  output logic                                shift_load,
  output logic [depth*width-1:0]              shift_parallel,
  output logic [width-1:0]                    shift_serial_in,
  output logic                                serial_valid,
  output logic                                serial_last,
  output logic [requesters-1:0]               owner
);
  localparam int dw = depth * width;
  localparam int pw = requesters > 1 ? $clog2(requesters) : 1;
  localparam int cw = depth > 1 ? $clog2(depth) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [cw-1:0] cnt, cnt_nx;
  logic [pw-1:0] ptr, ptr_nx, sel, idx;
  logic [requesters-1:0] pick, owner_nx;
  logic any, last, take, adv;
  // Scan from the farthest candidate back to ptr so the nearest set bit wins.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = requesters - 1; k >= 0; k--) begin
      idx = pw'((int'(ptr) + k) % requesters);
      if (request[idx]) sel = idx;
    end
  end
  always_comb begin
    any = |request;
    last = cnt == cw'(depth - 1);
    pick = any ? {{(requesters-1){1'b0}}, 1'b1} << sel : '0;
`ifdef SHIFT_BACK_TO_BACK_EN
    take = any & (state == IDLE | (state == SHIFT & ~stall & last));
`else
    take = any & state == IDLE;
`endif
    adv = state == SHIFT & ~stall;
    grant = reset_n & take ? pick : '0;
    shift_enable = reset_n & (take | adv);
    shift_load = reset_n & take;
    shift_parallel = reset_n & take ? data[int'(sel)*dw +: dw] : '0;
    shift_serial_in = '0;
    serial_valid = reset_n & state == SHIFT;
    serial_last = serial_valid & last;
    state_nx = take ? SHIFT : (adv & last) ? IDLE : state;
    cnt_nx = (take | (adv & last)) ? '0 : adv ? cnt + 1'b1 : cnt;
    ptr_nx = take ? (sel == pw'(requesters - 1) ? '0 : sel + 1'b1) : ptr;
    owner_nx = take ? pick : (adv & last) ? '0 : owner;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      owner <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ptr <= ptr_nx;
      owner <= owner_nx;
    end
  end
endmodule

// File: tb/tb_shift_scheduler.sv
// tb_shift_scheduler: directed checks of shift_scheduler with a 4x1-bit shift register model on its outputs.
module tb_shift_scheduler;
`ifdef SHIFT_BACK_TO_BACK_EN
  localparam bit bb = 1'b1;
`else
  localparam bit bb = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] request = '0;
  logic [15:0] data = '0;
  logic stall = 1'b0;
  logic [3:0] grant, shift_parallel, owner, sh;
  logic shift_enable, shift_load, serial_valid, serial_last;
  logic [0:0] shift_serial_in;
  int total = 0;
  int bad = 0;
  shift_scheduler dut (
    .clock(clock), .reset_n(reset_n), .request(request), .data(data), .stall(stall),
    .grant(grant), .shift_enable(shift_enable), .shift_load(shift_load),
    .shift_parallel(shift_parallel), .shift_serial_in(shift_serial_in),
    .serial_valid(serial_valid), .serial_last(serial_last), .owner(owner)
  );
  always #5 clock = ~clock;
  // LSB-first shifter: loads the parallel word, then shifts right; sh[0] is serial_out.
  always @(posedge clock)
    if (shift_enable) sh <= shift_load ? shift_parallel : {shift_serial_in, sh[3:1]};
  task tick;
    @(posedge clock);
    #1;
  endtask
  task do_reset;
    reset_n = 1'b0;
    request = '0;
    stall = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
  endtask
  task test_reset;
    reset_n = 1'b0;
    request = 4'hF;
    tick;
    tick;
    #1;
    total++;
    if ({grant, shift_enable, shift_load, serial_valid, serial_last} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got grant=%b en=%b ld=%b v=%b l=%b exp all 0", grant, shift_enable, shift_load, serial_valid, serial_last);
    end
    total++;
    if (owner !== 4'b0000) begin bad++; $display("FAIL reset_owner got=%b exp=0000", owner); end
    reset_n = 1'b1;
    request = '0;
  endtask
  task test_single;
    logic [3:0] e;
    e = 4'b1011;
    do_reset;
    data = 16'h5B3C;
    request = 4'b0100;
    #1;
    total++;
    if ({grant, shift_enable, shift_load, shift_parallel} !== {4'b0100, 1'b1, 1'b1, 4'b1011}) begin
      bad++;
      $display("FAIL single_grant got g=%b en=%b ld=%b par=%b exp g=0100 en=1 ld=1 par=1011", grant, shift_enable, shift_load, shift_parallel);
    end
    tick;
    request = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({serial_valid, sh[0], serial_last, owner, grant} !== {1'b1, e[i], i == 3, 4'b0100, 4'b0000}) begin
        bad++;
        $display("FAIL single_slice%0d got v=%b so=%b l=%b own=%b g=%b exp v=1 so=%b l=%b own=0100 g=0000", i, serial_valid, sh[0], serial_last, owner, grant, e[i], i == 3);
      end
      tick;
    end
    #1;
    total++;
    if ({serial_valid, owner} !== 5'b0) begin bad++; $display("FAIL single_end got v=%b own=%b exp 0", serial_valid, owner); end
  endtask
  task test_round_robin;
    logic [3:0] gv [5];
    logic [3:0] eg [5];
    int gc [5];
    logic gvalid [5];
    int n, vcnt;
    logic viol;
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    n = 0;
    vcnt = 0;
    viol = 1'b0;
    do_reset;
    data = 16'h1234;
    request = 4'hF;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (grant !== 4'b0000 && n < 5) begin
        gv[n] = grant;
        gc[n] = c;
        gvalid[n] = serial_valid;
        n++;
      end
      if (c >= 1 && c <= 16 && serial_valid === 1'b1) vcnt++;
      if (!$onehot0(grant) || (shift_load && !shift_enable)) viol = 1'b1;
      tick;
    end
    request = '0;
    total++;
    if (n !== 5) begin bad++; $display("FAIL rr_count got=%0d exp=5", n); end
    for (int k = 0; k < n; k++) begin
      total++;
      if (gv[k] !== eg[k] || gc[k] !== k * (bb ? 4 : 5) || (k > 0 && gvalid[k] !== bb)) begin
        bad++;
        $display("FAIL rr_grant%0d got g=%b cyc=%0d v=%b exp g=%b cyc=%0d v=%b", k, gv[k], gc[k], gvalid[k], eg[k], k * (bb ? 4 : 5), bb);
      end
    end
    total++;
    if (vcnt !== (bb ? 16 : 13)) begin bad++; $display("FAIL rr_valid_cycles got=%0d exp=%0d", vcnt, bb ? 16 : 13); end
    total++;
    if (viol !== 1'b0) begin bad++; $display("FAIL rr_onehot_load got=%b exp=0", viol); end
  endtask
  task test_stall;
    logic [6:0] so_e;
    logic [5:0] en_e;
    so_e = 7'b0111110;
    en_e = 6'b100011;
    do_reset;
    data = 16'h0006;
    request = 4'b0001;
    #1;
    total++;
    if (grant !== 4'b0001) begin bad++; $display("FAIL stall_grant got=%b exp=0001", grant); end
    tick;
    request = '0;
    for (int i = 0; i < 7; i++) begin
      stall = (i >= 2 && i <= 4);
      #1;
      total++;
      if ({serial_valid, sh[0], serial_last} !== {1'b1, so_e[i], i == 6} || (i < 6 && shift_enable !== en_e[i])) begin
        bad++;
        $display("FAIL stall_cycle%0d got v=%b so=%b l=%b en=%b exp v=1 so=%b l=%b en=%b", i, serial_valid, sh[0], serial_last, shift_enable, so_e[i], i == 6, i < 6 ? en_e[i] : shift_enable);
      end
      tick;
    end
    stall = 1'b0;
    #1;
    total++;
    if (serial_valid !== 1'b0) begin bad++; $display("FAIL stall_end got v=%b exp=0", serial_valid); end
  endtask
  task test_mid_reset;
    do_reset;
    data = 16'h00A0;
    request = 4'b0010;
    #1;
    total++;
    if (grant !== 4'b0010) begin bad++; $display("FAIL mrst_grant got=%b exp=0010", grant); end
    tick;
    request = '0;
    tick;
    reset_n = 1'b0;
    request = 4'b0010;
    #1;
    total++;
    if ({serial_valid, shift_enable, shift_load, grant} !== 7'b0) begin
      bad++;
      $display("FAIL mrst_during got v=%b en=%b ld=%b g=%b exp 0", serial_valid, shift_enable, shift_load, grant);
    end
    tick;
    reset_n = 1'b1;
    request = '0;
    #1;
    total++;
    if ({serial_valid, owner} !== 5'b0) begin bad++; $display("FAIL mrst_after got v=%b own=%b exp 0", serial_valid, owner); end
    request = 4'b1010;
    #1;
    total++;
    if (grant !== 4'b0010) begin bad++; $display("FAIL mrst_pointer got=%b exp=0010", grant); end
    tick;
    request = '0;
    #1;
    total++;
    if ({serial_valid, owner} !== 5'b10010) begin bad++; $display("FAIL mrst_regrant got v=%b own=%b exp v=1 own=0010", serial_valid, owner); end
  endtask
  task test_withdraw;
    do_reset;
    data = 16'h0400;
    request = 4'b0100;
    tick;
    for (int i = 0; i < 4; i++) begin
      request = i < 2 ? 4'b0001 : 4'b0000;
      #1;
      total++;
      if (grant !== 4'b0000 || owner !== 4'b0100 || serial_last !== (i == 3)) begin
        bad++;
        $display("FAIL wd_shift%0d got g=%b own=%b l=%b exp g=0000 own=0100 l=%b", i, grant, owner, serial_last, i == 3);
      end
      tick;
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if ({grant, serial_valid, owner} !== 9'b0) begin
        bad++;
        $display("FAIL wd_idle%0d got g=%b v=%b own=%b exp 0", i, grant, serial_valid, owner);
      end
      tick;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_stall;
    test_mid_reset;
    test_withdraw;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
